// File: rtl/pie_pkg.sv
// Shared PIE definitions: decoder state encoding and the default link timing
// (in clk cycles) common to the PIE encoder and decoder.
package pie_pkg;

  localparam int PW             = 125;
  localparam int ZERO_PERIOD    = 500;
  localparam int ONE_PERIOD     = 875;
  localparam int RTCAL_PERIOD   = ZERO_PERIOD + ONE_PERIOD;
  localparam int TRCAL_PERIOD   = 4000;
  localparam int DELIMITER      = 312;

  localparam int DELIM_MIN_DEF  = 250;
  localparam int DELIM_MAX_DEF  = 400;
  localparam int MAX_PERIOD_DEF = 4800;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DELIM,
    S_SYNC0,
    S_RTCAL,
    S_FIRST,
    S_DATA
  } pie_state_e;

endpackage

// File: rtl/pie_sync_edge.sv
// Two-flop synchronizer for the raw PIE line plus a delayed copy, giving
// single-cycle rise/fall strobes in the clk domain.
module pie_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic i_pie,
  output logic o_pie_s,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_dly;

  // NOTE: the line idles high, so these flops reset to 1; resetting to 0 would fake a rise after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_dly  <= 1'b1;
    end else begin
      r_meta <= i_pie;
      r_sync <= r_meta;
      r_dly  <= r_sync;
    end
  end

  assign o_pie_s = r_sync;
  assign o_rise  = r_sync & ~r_dly;
  assign o_fall  = ~r_sync & r_dly;

endmodule

// File: rtl/pie_decoder.sv
// Tag-side PIE receiver: validates the delimiter, measures RTCAL/TRCAL
// rise-to-rise and emits one registered bit strobe per data symbol.
module pie_decoder
  import pie_pkg::*;
#(
  parameter  int DELIM_MIN  = DELIM_MIN_DEF,
  parameter  int DELIM_MAX  = DELIM_MAX_DEF,
  parameter  int MAX_PERIOD = MAX_PERIOD_DEF,
  localparam int CW         = $clog2(MAX_PERIOD + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pie_in,
  output logic          out_bit,
  output logic          out_valid,
  output logic          frame_start,
  output logic          frame_end,
  output logic          preamble,
  output logic [CW-1:0] rtcal_len,
  output logic [CW-1:0] trcal_len,
  output logic          err
);

  localparam int LW = $clog2(DELIM_MAX + 2);

  logic          w_pie_s, w_rise, w_fall;
  pie_state_e    r_state, w_state_nxt;
  logic [CW-1:0] r_ivl, r_pivot, r_rtcal_len, r_trcal_len;
  logic [LW-1:0] r_low_cnt;
  logic          r_preamble, r_out_bit, r_out_valid, r_frame_start, r_frame_end, r_err;
  logic          w_valid_nxt, w_bit_nxt, w_start_nxt, w_end_nxt, w_err_nxt;
  logic          w_rtcal_ld, w_trcal_ld, w_in_frame, w_is_one;

  pie_sync_edge u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_pie   (pie_in),
    .o_pie_s (w_pie_s),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  assign w_in_frame = r_state inside {S_SYNC0, S_RTCAL, S_FIRST, S_DATA};
  assign w_is_one   = (r_ivl >= r_pivot);

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    w_state_nxt = r_state;
    w_valid_nxt = 1'b0;
    w_bit_nxt   = 1'b0;
    w_start_nxt = 1'b0;
    w_end_nxt   = 1'b0;
    w_err_nxt   = 1'b0;
    w_rtcal_ld  = 1'b0;
    w_trcal_ld  = 1'b0;
    unique case (r_state)
      S_IDLE: if (w_fall) w_state_nxt = S_DELIM;
      S_DELIM: begin
        if (w_rise) begin
          if (r_low_cnt >= LW'(DELIM_MIN) && r_low_cnt <= LW'(DELIM_MAX)) begin
            w_state_nxt = S_SYNC0;
            w_start_nxt = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
            w_err_nxt   = 1'b1;
          end
        end else if (!w_pie_s && r_low_cnt > LW'(DELIM_MAX)) begin
          w_state_nxt = S_IDLE;
          w_err_nxt   = 1'b1;
        end
      end
      S_SYNC0: if (w_rise) w_state_nxt = S_RTCAL;
      S_RTCAL: if (w_rise) begin
        w_rtcal_ld  = 1'b1;
        w_state_nxt = S_FIRST;
      end
      S_FIRST: if (w_rise) begin
        // An interval equal to RTCAL is still data; only a longer one is TRCAL.
        if (r_ivl > r_rtcal_len) begin
          w_trcal_ld = 1'b1;
        end else begin
          w_valid_nxt = 1'b1;
          w_bit_nxt   = w_is_one;
        end
        w_state_nxt = S_DATA;
      end
      S_DATA: if (w_rise) begin
        w_valid_nxt = 1'b1;
        w_bit_nxt   = w_is_one;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // A rise in the same cycle always takes precedence over abort/timeout.
    if (w_in_frame && !w_rise) begin
      if (!w_pie_s && r_low_cnt == LW'(DELIM_MIN)) begin
        w_state_nxt = S_DELIM;
        w_end_nxt   = 1'b1;
        w_err_nxt   = 1'b1;
      end else if (w_pie_s && r_ivl == CW'(MAX_PERIOD)) begin
        w_state_nxt = S_IDLE;
        w_end_nxt   = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_ivl         <= '0;
      r_low_cnt     <= '0;
      r_pivot       <= '0;
      r_rtcal_len   <= '0;
      r_trcal_len   <= '0;
      r_preamble    <= 1'b0;
      r_out_bit     <= 1'b0;
      r_out_valid   <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_end   <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_out_bit     <= w_bit_nxt;
      r_out_valid   <= w_valid_nxt;
      r_frame_start <= w_start_nxt;
      r_frame_end   <= w_end_nxt;
      r_err         <= w_err_nxt;

      if (w_rise)                       r_ivl <= CW'(1);
      else if (r_ivl < CW'(MAX_PERIOD)) r_ivl <= r_ivl + CW'(1);

      if (w_pie_s)                          r_low_cnt <= '0;
      else if (r_low_cnt <= LW'(DELIM_MAX)) r_low_cnt <= r_low_cnt + LW'(1);

      if (w_rtcal_ld) begin
        r_rtcal_len <= r_ivl;
        r_pivot     <= r_ivl >> 1;
      end

      if (w_start_nxt) begin
        r_preamble  <= 1'b0;
        r_trcal_len <= '0;
      end else if (w_trcal_ld) begin
        r_preamble  <= 1'b1;
        r_trcal_len <= r_ivl;
      end
    end
  end

  assign out_bit     = r_out_bit;
  assign out_valid   = r_out_valid;
  assign frame_start = r_frame_start;
  assign frame_end   = r_frame_end;
  assign preamble    = r_preamble;
  assign rtcal_len   = r_rtcal_len;
  assign trcal_len   = r_trcal_len;
  assign err         = r_err;

endmodule
